qdrc_phy_pattern_gen: RTL and testbench

Transmit-side calibration sequencer for the QDR PHY.
- On request, writes a walking-one training pattern into the first PATTERN_DEPTH QDR addresses, then issues reads of those addresses.
- Emits the expected rise/fall read data, time-aligned to READ_LATENCY, so a downstream bit trainer or checker can compare captured q data against it.
- Sits beside the read-side bit-alignment logic and drives the same d/bw_n/w_n/r_n/sa PHY inputs.

---
 rtl/qdrc_phy_pattern_gen.sv | 141 ++++++++++++++
 tb/tb_qdrc_phy_pattern_gen.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/qdrc_phy_pattern_gen.sv
// QDR PHY calibration sequencer: writes a walking-one pattern, reads it back,
// and emits the expected read data aligned to the read latency.
module qdrc_phy_pattern_gen #(
    parameter int DATA_WIDTH    = 18,
    parameter int BW_WIDTH      = 2,
    parameter int ADDR_WIDTH    = 21,
    parameter int PATTERN_DEPTH = 8,
    parameter int GAP_CYCLES    = 16,
    parameter int READ_LATENCY  = 10
) (
    input  logic                  clk0,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  qdr_w_n,
    output logic                  qdr_r_n,
    output logic [ADDR_WIDTH-1:0] qdr_sa,
    output logic [DATA_WIDTH-1:0] qdr_d_rise,
    output logic [DATA_WIDTH-1:0] qdr_d_fall,
    output logic [BW_WIDTH-1:0]   qdr_bw_n_rise,
    output logic [BW_WIDTH-1:0]   qdr_bw_n_fall,
    output logic                  exp_valid,
    output logic [DATA_WIDTH-1:0] exp_rise,
    output logic [DATA_WIDTH-1:0] exp_fall
);

    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IW-1:0] LAST_K = IW'(PATTERN_DEPTH - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    // Only the oldest read still in flight: the final expected word is on the outputs.
    localparam logic [READ_LATENCY-1:0] DRAIN_END = READ_LATENCY'(1) << (READ_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, DRAIN, DONE} state_t;

    state_t                  state;
    logic [IW-1:0]           k;
    logic [IW-1:0]           k_nxt;
    logic [7:0]              gap_cnt;
    logic [READ_LATENCY-1:0] vld_pipe;
    logic [DATA_WIDTH-1:0]   rise_pipe [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   fall_pipe [READ_LATENCY];

    function automatic logic [DATA_WIDTH-1:0] walk1(input logic [IW-1:0] idx);
        return DATA_WIDTH'(1) << idx;
    endfunction

    assign k_nxt         = k + 1'b1;
    assign qdr_bw_n_rise = '0;
    assign qdr_bw_n_fall = '0;
    assign exp_valid     = vld_pipe[READ_LATENCY-1];
    assign exp_rise      = rise_pipe[READ_LATENCY-1];
    assign exp_fall      = fall_pipe[READ_LATENCY-1];

    always_ff @(posedge clk0) begin
        if (!reset_n) begin
            state      <= IDLE;
            k          <= '0;
            gap_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            qdr_w_n    <= 1'b1;
            qdr_r_n    <= 1'b1;
            qdr_sa     <= '0;
            qdr_d_rise <= '0;
            qdr_d_fall <= '0;
            vld_pipe   <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                rise_pipe[i] <= '0;
                fall_pipe[i] <= '0;
            end
        end else begin
            // Stage 0 captures the read on the bus this cycle; data is zero when idle.
            vld_pipe[0]  <= ~qdr_r_n;
            rise_pipe[0] <= qdr_r_n ? '0 : walk1(k);
            fall_pipe[0] <= qdr_r_n ? '0 : ~walk1(k);
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                rise_pipe[i] <= rise_pipe[i-1];
                fall_pipe[i] <= fall_pipe[i-1];
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= WRITE;
                        k          <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        qdr_w_n    <= 1'b0;
                        qdr_sa     <= '0;
                        qdr_d_rise <= walk1('0);
                        qdr_d_fall <= ~walk1('0);
                    end
                end
                WRITE: begin
                    if (k == LAST_K) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                        qdr_w_n <= 1'b1;
                        qdr_sa  <= '0;
                    end else begin
                        k          <= k_nxt;
                        qdr_sa     <= ADDR_WIDTH'(k_nxt);
                        qdr_d_rise <= walk1(k_nxt);
                        qdr_d_fall <= ~walk1(k_nxt);
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state   <= READ;
                        k       <= '0;
                        qdr_r_n <= 1'b0;
                        qdr_sa  <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                READ: begin
                    if (k == LAST_K) begin
                        state   <= DRAIN;
                        qdr_r_n <= 1'b1;
                        qdr_sa  <= '0;
                    end else begin
                        k      <= k_nxt;
                        qdr_sa <= ADDR_WIDTH'(k_nxt);
                    end
                end
                DRAIN: begin
                    if (vld_pipe == DRAIN_END) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qdrc_phy_pattern_gen.sv
// Bench for qdrc_phy_pattern_gen: default instance plus a minimal-depth instance,
// both checked every cycle against a schedule model derived from sequence offsets.
module tb_qdrc_phy_pattern_gen;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        w_n;
        logic        r_n;
        logic [20:0] sa;
        logic [17:0] dr;
        logic [17:0] df;
        logic [1:0]  bwr;
        logic [1:0]  bwf;
        logic        ev;
        logic [17:0] er;
        logic [17:0] ef;
    } obs_t;

    logic clk0, reset_n, start;

    logic        a_busy, a_done, a_w_n, a_r_n, a_ev;
    logic [20:0] a_sa;
    logic [17:0] a_dr, a_df, a_er, a_ef;
    logic [1:0]  a_bwr, a_bwf;
    logic        b_busy, b_done, b_w_n, b_r_n, b_ev;
    logic [20:0] b_sa;
    logic [17:0] b_dr, b_df, b_er, b_ef;
    logic [1:0]  b_bwr, b_bwf;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0a = 0, t0b = 0;
    bit acta = 0, actb = 0;

    qdrc_phy_pattern_gen u_dut_a (
        .clk0(clk0), .reset_n(reset_n), .start(start), .busy(a_busy), .done(a_done),
        .qdr_w_n(a_w_n), .qdr_r_n(a_r_n), .qdr_sa(a_sa), .qdr_d_rise(a_dr), .qdr_d_fall(a_df),
        .qdr_bw_n_rise(a_bwr), .qdr_bw_n_fall(a_bwf), .exp_valid(a_ev), .exp_rise(a_er),
        .exp_fall(a_ef)
    );

    qdrc_phy_pattern_gen #(.PATTERN_DEPTH(1), .GAP_CYCLES(1), .READ_LATENCY(1)) u_dut_b (
        .clk0(clk0), .reset_n(reset_n), .start(start), .busy(b_busy), .done(b_done),
        .qdr_w_n(b_w_n), .qdr_r_n(b_r_n), .qdr_sa(b_sa), .qdr_d_rise(b_dr), .qdr_d_fall(b_df),
        .qdr_bw_n_rise(b_bwr), .qdr_bw_n_fall(b_bwf), .exp_valid(b_ev), .exp_rise(b_er),
        .exp_fall(b_ef)
    );

    initial begin
        clk0 = 1'b0;
        forever #5 clk0 = ~clk0;
    end

    // Expected outputs o cycles after the first write of the current sequence.
    function automatic obs_t model(input int pd, input int g, input int l, input bit act,
                                   input int o);
        obs_t e;
        int   rd0, ev0;
        e     = '0;
        e.w_n = 1'b1;
        e.r_n = 1'b1;
        rd0   = pd + g;
        ev0   = pd + g + l;
        if (act) begin
            if (o < pd) begin
                e.w_n = 1'b0;
                e.sa  = 21'(o);
            end
            if (o >= rd0 && o < rd0 + pd) begin
                e.r_n = 1'b0;
                e.sa  = 21'(o - rd0);
            end
            e.dr = 18'd1 << ((o < pd) ? o : pd - 1);
            e.df = ~e.dr;
            if (o >= ev0 && o < ev0 + pd) begin
                e.ev = 1'b1;
                e.er = 18'd1 << (o - ev0);
                e.ef = ~e.er;
            end
            e.busy = (o < ev0 + pd);
            e.done = (o >= ev0 + pd);
        end
        return e;
    endfunction

    task automatic check_all();
        obs_t ea, eb, oa, ob;
        ea = model(8, 16, 10, acta, cyc - t0a);
        eb = model(1, 1, 1, actb, cyc - t0b);
        oa = {a_busy, a_done, a_w_n, a_r_n, a_sa, a_dr, a_df, a_bwr, a_bwf, a_ev, a_er, a_ef};
        ob = {b_busy, b_done, b_w_n, b_r_n, b_sa, b_dr, b_df, b_bwr, b_bwf, b_ev, b_er, b_ef};
        n_cmp++;
        assert (oa === ea) else begin
            n_err++;
            $error("FAIL dflt cyc=%0d observed=%h expected=%h", cyc, oa, ea);
        end
        n_cmp++;
        assert (ob === eb) else begin
            n_err++;
            $error("FAIL min cyc=%0d observed=%h expected=%h", cyc, ob, eb);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check on the falling edge.
    task automatic step(input logic rst, input logic st);
        reset_n = rst;
        start   = st;
        @(posedge clk0);
        if (!rst) begin
            acta = 0;
            actb = 0;
        end else if (st) begin
            if (!acta || (cyc - t0a) >= 42) begin
                acta = 1;
                t0a  = cyc + 1;
            end
            if (!actb || (cyc - t0b) >= 4) begin
                actb = 1;
                t0b  = cyc + 1;
            end
        end
        cyc++;
        @(negedge clk0);
        check_all();
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        // reset for 3 cycles, then idle
        repeat (3) step(1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0);
        // full sequence from a single start pulse
        step(1'b1, 1'b1);
        repeat (50) step(1'b1, 1'b0);
        // reset during the read phase, after three reads
        step(1'b1, 1'b1);
        repeat (26) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        repeat (12) step(1'b1, 1'b0);
        // start pulses in GAP and DRAIN are ignored
        step(1'b1, 1'b1);
        repeat (12) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (22) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (14) step(1'b1, 1'b0);
        // start held high: back-to-back sequences
        repeat (100) step(1'b1, 1'b1);
        repeat (50) step(1'b1, 1'b0);
        // randomized start pulses and occasional resets
        for (int it = 0; it < 40; it++) begin
            int n;
            n = $urandom_range(60, 1);
            for (int c = 0; c < n; c++)
                step(($urandom_range(99, 0) != 0), ($urandom_range(9, 0) == 0));
        end
        repeat (50) step(1'b1, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
